tft_frame_capture: RTL and testbench
====================================

// Module: tft_frame_capture
// PURPOSE
//  Receive side of the parallel RGB TFT interface (pixel clock, DE, 8/8/8 RGB): samples an external
//  RGB source and writes each active pixel as RGB332 into the two 64 KiB on-chip frame RAM banks
//  (ram1 = linear address bit16==0, ram2 = bit16==1) that the display scan-out reads.
//  Sits in the 50 MHz fabric domain next to soc_system; pixel clock is oversampled, not used as a clock.
// PARAMETERS
//  H_ACTIVE    480   active pixels per line (DE-high pixel clocks)
//  V_ACTIVE    272   active lines per frame
//  VBLANK_MIN  1024  consecutive DE-low pixel clocks that mark vertical blank (> line blank of 257)
// PORTS
//  clk             in   1   fabric clock, FPGA_CLK1_50 (50 MHz); pixel clock must be <= clk/4
//  rst_n           in   1   asynchronous active-low reset
//  capture_en      in   1   level; arms capture (single-shot) / keeps capturing (continuous)
//  continuous      in   1   1 = capture every frame while capture_en high; sampled in IDLE only
//  pix_clk_in      in   1   external pixel clock (async)
//  de_in           in   1   external data enable (async, changes with pix_clk_in)
//  r_in/g_in/b_in  in   8 each   external colour components (async)
//  ram1_address    out  16  bank-1 address;  ram1_write out 1 write strobe;  ram1_writedata out 8
//  ram2_address    out  16  bank-2 address;  ram2_write out 1 write strobe;  ram2_writedata out 8
//  busy            out  1   high in WAIT_VB and CAPTURE
//  frame_done      out  1   one-clk pulse at end of each captured frame
//  err             out  1   sticky: DE pixel beyond H_ACTIVE or line beyond V_ACTIVE seen
// BEHAVIOUR
//  - Sync: pix_clk_in, de_in, r/g/b each through 2 flops; third flop on pix_clk gives edge detect.
//    Pixel event = sync_pclk==1 && prev_pclk==0; DE/RGB taken from the same sync stage.
//  - Pack: byte = {r[7:5], g[7:6], b[7:5]}.
//  - Position: x (9b), y (9b), blank counter (11b, saturating at VBLANK_MIN).
//    event&DE: write if x<H_ACTIVE && y<V_ACTIVE, else set err; x<=x+1; blank<=0.
//    event&!DE: if previous event had DE=1 -> x<=0, y<=y+1; blank<=blank+1 (sat).
//    blank reaching VBLANK_MIN (edge of the count, once) = vblank event: x<=0, y<=0.
//  - Address: lin = y*H_ACTIVE + x (17b). lin[16]==0 -> ram1_address=lin[15:0], ram1_write;
//    lin[16]==1 -> ram2_address=lin[15:0], ram2_write. Only one bank written per pixel.
//  - Latency: write strobe is high exactly 1 clk, in the clk after the pixel event (3-4 clk after pin
//    edge); address/data valid in that same clk; idle bank address held 0, strobes 0 otherwise.
//  - FSM: IDLE -(capture_en)-> WAIT_VB -(vblank event)-> CAPTURE.
//    CAPTURE -(vblank event, >=1 pixel written)-> frame_done pulse; continuous&&capture_en: stay
//    CAPTURE; else DONE. DONE -(!capture_en)-> IDLE. capture_en low in WAIT_VB -> IDLE;
//    low in CAPTURE -> finish current frame then DONE. Writes only occur in CAPTURE.
//  - err cleared on IDLE->WAIT_VB transition. Position tracking runs in all states.
//  - Reset (any time, incl. mid-frame): state IDLE, x=y=blank=0, all outputs 0; in-progress frame
//    abandoned, no frame_done.
// CONFIGURATION
//  TFT_CAP_PIXCNT_EN defined: extra port pix_count out 17 = pixels written in last completed frame,
//   updated with frame_done, reset 0. Undefined: port and counter absent, behaviour otherwise identical.
// TESTING
//  1 480x272 frame, all pixels r=E0 g=00 b=00, single-shot -> 65536 ram1 writes addr 0..65535 and
//    65024 ram2 writes addr 0..65023, all data 0xE0; one frame_done; pix_count=130560.
//  2 Pixel x=5,y=1 r=20 g=40 b=A0 -> ram1_address=485, ram1_writedata=0x2D, 1 clk strobe.
//  3 capture_en raised mid-frame (line 100) -> zero writes until next vblank; first write addr 0.
//  4 Line 0 with 481 DE clocks -> 480 writes, err=1 and stays 1 through frame_done; re-arm clears it.
//  5 rst_n low during line 50 -> outputs 0 same clk, FSM IDLE, no frame_done; no writes after release
//    until capture_en again.
//  6 continuous=1, 3 frames, capture_en dropped in frame 3 -> 3 frame_done pulses, then DONE->IDLE.

Source files
------------

// File: rtl/tft_frame_capture.sv
// tft_frame_capture
//   Receive side of a parallel RGB TFT interface. The external pixel clock,
//   DE and colour bus are oversampled in the fabric clock domain. Each active
//   pixel is written as RGB332 into one of two 64 KiB frame RAM banks, split
//   on bit 16 of the linear pixel address.
//
//   Optional feature macro: TFT_CAP_PIXCNT_EN adds the pix_count output.
//
// Ports
//   clk, rst_n          fabric clock, asynchronous active-low reset
//   capture_en          arms single-shot capture / keeps continuous capture
//   continuous          capture every frame (latched when leaving IDLE)
//   pix_clk_in, de_in   external pixel clock and data enable (asynchronous)
//   r_in, g_in, b_in    external 8-bit colour components (asynchronous)
//   ram1_*              bank 1 write port (linear address bit16 == 0)
//   ram2_*              bank 2 write port (linear address bit16 == 1)
//   busy                high while waiting for vblank or capturing
//   frame_done          one-clock pulse when a captured frame completes
//   err                 sticky out-of-range DE pixel / line indication
//   pix_count           (TFT_CAP_PIXCNT_EN) pixels written in last frame
module tft_frame_capture #(
  parameter int unsigned H_ACTIVE   = 480,
  parameter int unsigned V_ACTIVE   = 272,
  parameter int unsigned VBLANK_MIN = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture_en,
  input  logic        continuous,
  input  logic        pix_clk_in,
  input  logic        de_in,
  input  logic [7:0]  r_in,
  input  logic [7:0]  g_in,
  input  logic [7:0]  b_in,
  output logic [15:0] ram1_address,
  output logic        ram1_write,
  output logic [7:0]  ram1_writedata,
  output logic [15:0] ram2_address,
  output logic        ram2_write,
  output logic [7:0]  ram2_writedata,
  output logic        busy,
  output logic        frame_done,
  output logic        err
`ifdef TFT_CAP_PIXCNT_EN
  ,
  output logic [16:0] pix_count
`endif
);

  localparam logic [8:0]  H_LIM   = 9'(H_ACTIVE);
  localparam logic [8:0]  V_LIM   = 9'(V_ACTIVE);
  localparam logic [10:0] VB_LIM  = 11'(VBLANK_MIN);
  localparam logic [10:0] VB_LAST = 11'(VBLANK_MIN - 1);

  typedef enum logic [1:0] {IDLE, WAIT_VB, CAPTURE, DONE} state_t;

  state_t      state;
  logic        cont_q;
  logic [16:0] frame_pixels;

  // Only the colour bits that survive RGB332 packing are synchronised.
  logic       pclk_s1, pclk_s2, pclk_prev;
  logic [8:0] bus_s1, bus_s2;
  logic       unused_bits;

  logic [8:0]  x, y;
  logic [10:0] blank;
  logic        last_de;

  logic        de_s;
  logic [7:0]  pix_byte;
  logic        pix_event, in_range, pixel_wr, vblank_evt, oob;
  logic [16:0] lin;

  assign unused_bits = ^{r_in[4:0], g_in[5:0], b_in[4:0]};

  assign de_s       = bus_s2[8];
  assign pix_byte   = bus_s2[7:0];
  assign pix_event  = pclk_s2 & ~pclk_prev;
  assign in_range   = (x < H_LIM) && (y < V_LIM);
  assign pixel_wr   = pix_event & de_s & in_range & (state == CAPTURE);
  assign oob        = pix_event & de_s & ~in_range;
  // vblank fires once, on the DE-low event that takes the count to the limit.
  assign vblank_evt = pix_event & ~de_s & (blank == VB_LAST);
  assign lin        = 17'(y) * 17'(H_ACTIVE) + 17'(x);

  // Two-flop synchronisers; the extra pclk flop gives the rising-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk_s1   <= 1'b0;
      pclk_s2   <= 1'b0;
      pclk_prev <= 1'b0;
      bus_s1    <= '0;
      bus_s2    <= '0;
    end else begin
      pclk_s1   <= pix_clk_in;
      pclk_s2   <= pclk_s1;
      pclk_prev <= pclk_s2;
      bus_s1    <= {de_in, r_in[7:5], g_in[7:6], b_in[7:5]};
      bus_s2    <= bus_s1;
    end
  end

  // Raster position tracking runs regardless of capture state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= '0;
      y       <= '0;
      blank   <= '0;
      last_de <= 1'b0;
    end else if (pix_event) begin
      if (de_s) begin
        x     <= x + 9'd1;
        blank <= '0;
      end else begin
        if (last_de) begin
          x <= '0;
          y <= y + 9'd1;
        end
        if (vblank_evt) begin
          x <= '0;
          y <= '0;
        end
        if (blank != VB_LIM) blank <= blank + 11'd1;
      end
      last_de <= de_s;
    end
  end

  // Bank write ports: strobe, address and data live for exactly one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram1_address   <= '0;
      ram1_write     <= 1'b0;
      ram1_writedata <= '0;
      ram2_address   <= '0;
      ram2_write     <= 1'b0;
      ram2_writedata <= '0;
    end else begin
      ram1_address   <= '0;
      ram1_write     <= 1'b0;
      ram1_writedata <= '0;
      ram2_address   <= '0;
      ram2_write     <= 1'b0;
      ram2_writedata <= '0;
      if (pixel_wr) begin
        if (lin[16]) begin
          ram2_address   <= lin[15:0];
          ram2_write     <= 1'b1;
          ram2_writedata <= pix_byte;
        end else begin
          ram1_address   <= lin[15:0];
          ram1_write     <= 1'b1;
          ram1_writedata <= pix_byte;
        end
      end
    end
  end

  // Capture sequencing. A frame only counts as done if it wrote a pixel;
  // dropping capture_en mid-frame lets the current frame finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cont_q       <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      err          <= 1'b0;
      frame_pixels <= '0;
`ifdef TFT_CAP_PIXCNT_EN
      pix_count    <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (capture_en) begin
            state  <= WAIT_VB;
            busy   <= 1'b1;
            cont_q <= continuous;
          end
        end
        WAIT_VB: begin
          if (!capture_en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (vblank_evt) begin
            state        <= CAPTURE;
            frame_pixels <= '0;
          end
        end
        CAPTURE: begin
          if (pixel_wr) frame_pixels <= frame_pixels + 17'd1;
          if (vblank_evt) begin
            if (frame_pixels != '0) begin
              frame_done   <= 1'b1;
              frame_pixels <= '0;
`ifdef TFT_CAP_PIXCNT_EN
              pix_count    <= frame_pixels;
`endif
              if (!(cont_q && capture_en)) begin
                state <= DONE;
                busy  <= 1'b0;
              end
            end else if (!capture_en) begin
              state <= DONE;
              busy  <= 1'b0;
            end
          end
        end
        DONE: begin
          if (!capture_en) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      // Re-arming clears the sticky error; otherwise any out-of-range DE sets it.
      if (state == IDLE && capture_en) err <= 1'b0;
      else if (oob) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tft_frame_capture.sv
// tb_tft_frame_capture
//   Directed bench for tft_frame_capture. A behavioural raster/capture model
//   queues the expected bank writes as pixels are driven on the pins; a
//   monitor pops and compares each write the DUT produces.
module tb_tft_frame_capture;

  localparam int H  = 480;
  localparam int V  = 272;
  localparam int VB = 1024;

  logic        clk = 1'b0;
  logic        rst_n, capture_en, continuous, pix_clk_in, de_in;
  logic [7:0]  r_in, g_in, b_in;
  logic [15:0] ram1_address, ram2_address;
  logic        ram1_write, ram2_write;
  logic [7:0]  ram1_writedata, ram2_writedata;
  logic        busy, frame_done, err;
`ifdef TFT_CAP_PIXCNT_EN
  logic [16:0] pix_count;
`endif

  tft_frame_capture dut (
    .clk(clk), .rst_n(rst_n), .capture_en(capture_en), .continuous(continuous),
    .pix_clk_in(pix_clk_in), .de_in(de_in), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .ram1_address(ram1_address), .ram1_write(ram1_write), .ram1_writedata(ram1_writedata),
    .ram2_address(ram2_address), .ram2_write(ram2_write), .ram2_writedata(ram2_writedata),
    .busy(busy), .frame_done(frame_done), .err(err)
`ifdef TFT_CAP_PIXCNT_EN
    , .pix_count(pix_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_count = 0;

  typedef enum {M_IDLE, M_WAIT, M_CAP, M_DONE} mstate_t;
  mstate_t ms = M_IDLE;
  int  mx = 0, my = 0, mblank = 0, mwritten = 0, exp_fd = 0, exp_pixcnt = 0;
  bit  mlast_de = 0, merr = 0, mcont = 0;

  logic [24:0] exp_q[$];
  int          rise_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] pack(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return {r[7:5], g[7:6], b[7:5]};
  endfunction

  // Level-driven capture transitions, evaluated before each pixel edge.
  task automatic update_level();
    if (ms == M_DONE && !capture_en) ms = M_IDLE;
    if (ms == M_WAIT && !capture_en) ms = M_IDLE;
    if (ms == M_IDLE && capture_en) begin
      ms = M_WAIT; mcont = continuous; merr = 0;
    end
  endtask

  task automatic model_vblank();
    mx = 0; my = 0;
    if (ms == M_WAIT) begin
      ms = M_CAP; mwritten = 0;
    end else if (ms == M_CAP) begin
      if (mwritten > 0) begin
        exp_fd++; exp_pixcnt = mwritten; mwritten = 0;
        if (!(mcont && capture_en)) ms = M_DONE;
      end else if (!capture_en) ms = M_DONE;
    end
  endtask

  // One pixel clock period: 2 clocks low (data changes), 2 clocks high.
  task automatic applyStimulus(input logic d, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int lin;
    @(negedge clk);
    pix_clk_in = 1'b0; de_in = d; r_in = r; g_in = g; b_in = b;
    update_level();
    @(negedge clk);
    @(negedge clk);
    pix_clk_in = 1'b1;
    if (d) begin
      if (mx < H && my < V) begin
        if (ms == M_CAP) begin
          lin = my * H + mx;
          exp_q.push_back({lin[16], lin[15:0], pack(r, g, b)});
          rise_q.push_back(cyc);
          mwritten++;
        end
      end else merr = 1;
      mx++; mblank = 0;
    end else begin
      if (mlast_de) begin mx = 0; my++; end
      if (mblank < VB) begin
        mblank++;
        if (mblank == VB) model_vblank();
      end
    end
    mlast_de = d;
    @(negedge clk);
  endtask

  task automatic send_blank(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    update_level();
  endtask

  task automatic short_lines(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 8'hE0, 8'h00, 8'h00);
      send_blank(2);
    end
  endtask

  // Write / frame_done monitor, sampling on the falling edge.
  logic        prev_wr = 1'b0, prev_fd = 1'b0;
  logic [24:0] e;
  int          rc;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wr = 1'b0; prev_fd = 1'b0;
    end else begin
      if (frame_done) begin
        fd_count++;
        check("frame_done_width", prev_fd, 0);
      end
      if (ram1_write || ram2_write) begin
        check("one_bank", ram1_write & ram2_write, 0);
        check("strobe_width", prev_wr, 0);
        check("idle_bank_addr", ram1_write ? ram2_address : ram1_address, 0);
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $error("FAIL unexpected_write observed bank2=%0b addr=0x%0h expected=no write",
                 ram2_write, ram2_write ? ram2_address : ram1_address);
        end else begin
          e  = exp_q.pop_front();
          rc = rise_q.pop_front();
          check("write_bank_addr_data",
                {ram2_write, ram2_write ? ram2_address : ram1_address,
                 ram2_write ? ram2_writedata : ram1_writedata}, e);
          check("write_latency", ((cyc - rc) >= 3 && (cyc - rc) <= 4) ? 1 : 0, 1);
        end
      end
      prev_wr = ram1_write | ram2_write;
      prev_fd = frame_done;
    end
  end

  task automatic checkOutput(input string tag);
    check({tag, "_frame_done_count"}, fd_count, exp_fd);
    check({tag, "_busy"}, busy, (ms == M_WAIT || ms == M_CAP) ? 1 : 0);
    check({tag, "_err"}, err, merr);
`ifdef TFT_CAP_PIXCNT_EN
    check({tag, "_pix_count"}, pix_count, exp_pixcnt);
`endif
  endtask

  initial begin
    rst_n = 1'b0; capture_en = 1'b0; continuous = 1'b0;
    pix_clk_in = 1'b0; de_in = 1'b0; r_in = '0; g_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    #1 check("reset_outputs", {ram1_address, ram1_write, ram1_writedata, ram2_address,
                               ram2_write, ram2_writedata, busy, frame_done, err}, 0);
    @(negedge clk) rst_n = 1'b1;

    // Single-shot frame: full line, a marked pixel, many short lines, bank-2 line.
    capture_en = 1'b1;
    idle(3);
    checkOutput("armed");
    send_blank(1030);
    checkOutput("capturing");
    for (int i = 0; i < H; i++) applyStimulus(1'b1, 8'(i), 8'(i * 3), 8'(i ^ 8'hA5));
    send_blank(20);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) applyStimulus(1'b1, 8'h20, 8'h40, 8'hA0);
      else        applyStimulus(1'b1, 8'hE0, 8'h00, 8'h00);
    end
    send_blank(20);
    short_lines(140);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h13, 8'hC7, 8'h66);
    send_blank(1030);
    idle(2);
    checkOutput("single_shot_done");
    check("queue_drained_1", exp_q.size(), 0);
    capture_en = 1'b0;
    idle(3);

    // Arm mid-frame: nothing written until the next vblank.
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 30; i++) begin
        if (l == 2 && i == 10) capture_en = 1'b1;
        applyStimulus(1'b1, 8'hFF, 8'hFF, 8'hFF);
      end
      send_blank(20);
    end
    checkOutput("armed_midframe");
    send_blank(1030);

    // Over-long first line: 480 writes then a sticky error.
    for (int i = 0; i < H + 1; i++) applyStimulus(1'b1, 8'h80, 8'h80, 8'h80);
    send_blank(20);
    checkOutput("overlong_line");
    send_blank(1030);
    idle(2);
    checkOutput("overlong_frame_done");
    capture_en = 1'b0;
    idle(3);
    capture_en = 1'b1;
    idle(3);
    checkOutput("rearm_clears_err");

    // Reset in the middle of line 50.
    send_blank(1030);
    short_lines(50);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h44, 8'h55, 8'h66);
    @(negedge clk);
    rst_n = 1'b0; pix_clk_in = 1'b0; de_in = 1'b0; capture_en = 1'b0;
    ms = M_IDLE; mx = 0; my = 0; mblank = 0; mlast_de = 0; merr = 0; mwritten = 0;
    exp_q.delete(); rise_q.delete();
    #1 check("midframe_reset_outputs", {ram1_address, ram1_write, ram1_writedata, ram2_address,
                                        ram2_write, ram2_writedata, busy, frame_done, err}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'h44, 8'h55, 8'h66);
    send_blank(1030);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'h44, 8'h55, 8'h66);
    send_blank(20);
    checkOutput("after_reset");

    // Continuous capture over three frames, capture_en dropped during the third.
    continuous = 1'b1; capture_en = 1'b1;
    idle(3);
    send_blank(1030);
    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < 2; l++) begin
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(f * 64 + l), 8'hC0, 8'(i * 32));
        send_blank(2);
        if (f == 2 && l == 0) capture_en = 1'b0;
      end
      send_blank(1030);
      idle(2);
      checkOutput("continuous_frame");
    end
    idle(3);
    continuous = 1'b0; capture_en = 1'b1;
    idle(3);
    checkOutput("back_to_idle_rearm");
    capture_en = 1'b0;
    idle(3);
    check("queue_drained_end", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
